// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags.
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low)
//   commit side : write_en, reg_id, rob_id, value_in, clear_all
//   rename side : rename_en, rename_rd, rename_tag
//   lookup side : rs1_id/rs2_id -> rsN_value, rsN_busy, rsN_tag (tag valid only when busy)
//   Optional macro REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit onto the read ports.
module reg_rename_file #(
    parameter int REG_COUNT     = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     write_en,
    input  logic [REG_ID_BIT-1:0]    reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] rob_id,
    input  logic [31:0]              value_in,
    input  logic                     clear_all,
    input  logic                     rename_en,
    input  logic [REG_ID_BIT-1:0]    rename_rd,
    input  logic [ROB_WIDTH_BIT-1:0] rename_tag,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic [31:0]              rs1_value,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [31:0]              rs2_value,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);
    logic [31:0]              value_q [REG_COUNT];
    logic [ROB_WIDTH_BIT-1:0] tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0]     busy_q;

    // Entry 0 is never written, so x0 stays at its reset value of zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (write_en && reg_id != '0)
                value_q[reg_id] <= value_in;
            for (int i = 1; i < REG_COUNT; i++) begin
                if (clear_all)
                    busy_q[i] <= 1'b0;
                else if (rename_en && rename_rd == REG_ID_BIT'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= rename_tag;
                end else if (write_en && reg_id == REG_ID_BIT'(i) && tag_q[i] == rob_id)
                    busy_q[i] <= 1'b0;
            end
        end
    end

    logic [REG_ID_BIT-1:0]    rs_id    [2];
    logic [31:0]              rs_value [2];
    logic [1:0]               rs_busy;
    logic [ROB_WIDTH_BIT-1:0] rs_tag   [2];

    assign rs_id[0] = rs1_id;
    assign rs_id[1] = rs2_id;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic nz, byp;
        assign nz = rs_id[p] != '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        assign byp = write_en && nz && rs_id[p] == reg_id;
`else
        assign byp = 1'b0;
`endif
        // A bypassed commit only frees the register if it is the current producer.
        assign rs_value[p] = !nz ? '0 : byp ? value_in : value_q[rs_id[p]];
        assign rs_busy[p]  = nz && busy_q[rs_id[p]] && !(byp && tag_q[rs_id[p]] == rob_id);
        assign rs_tag[p]   = nz ? tag_q[rs_id[p]] : '0;
    end

    assign rs1_value = rs_value[0];
    assign rs1_busy  = rs_busy[0];
    assign rs1_tag   = rs_tag[0];
    assign rs2_value = rs_value[1];
    assign rs2_busy  = rs_busy[1];
    assign rs2_tag   = rs_tag[1];
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: randomized and directed checks of reg_rename_file against a behavioural model.
module tb_reg_rename_file;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        write_en = 1'b0;
    logic [4:0]  reg_id = '0;
    logic [3:0]  rob_id = '0;
    logic [31:0] value_in = '0;
    logic        clear_all = 1'b0;
    logic        rename_en = 1'b0;
    logic [4:0]  rename_rd = '0;
    logic [3:0]  rename_tag = '0;
    logic [4:0]  rs1_id = '0;
    logic [4:0]  rs2_id = '0;
    logic [31:0] rs1_value, rs2_value;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;

    reg_rename_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .write_en(write_en), .reg_id(reg_id), .rob_id(rob_id), .value_in(value_in),
        .clear_all(clear_all), .rename_en(rename_en), .rename_rd(rename_rd),
        .rename_tag(rename_tag), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected read of one operand given the model state and the current commit inputs.
    task automatic expect_read(input logic [4:0] id, output logic [31:0] v,
                               output logic b, output logic [3:0] t);
        v = '0; b = 1'b0; t = '0;
        if (id != 0) begin
            v = m_val[id];
            b = m_busy[id];
            t = m_tag[id];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (write_en && reg_id == id) begin
                v = value_in;
                if (m_tag[id] == rob_id) b = 1'b0;
            end
`endif
        end
    endtask

    task automatic compare_reads();
        logic [31:0] v;
        logic        b;
        logic [3:0]  t;
        expect_read(rs1_id, v, b, t);
        check("rs1_value", rs1_value, v);
        check("rs1_busy", 32'(rs1_busy), 32'(b));
        if (b) check("rs1_tag", 32'(rs1_tag), 32'(t));
        expect_read(rs2_id, v, b, t);
        check("rs2_value", rs2_value, v);
        check("rs2_busy", 32'(rs2_busy), 32'(b));
        if (b) check("rs2_tag", 32'(rs2_tag), 32'(t));
    endtask

    // Architectural effect of one clock edge.
    task automatic model_edge();
        if (!rdy_in) return;
        if (write_en && reg_id != 0) m_val[reg_id] = value_in;
        if (clear_all) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (write_en && reg_id != 0 && m_tag[reg_id] == rob_id) m_busy[reg_id] = 1'b0;
            if (rename_en && rename_rd != 0) begin
                m_busy[rename_rd] = 1'b1;
                m_tag[rename_rd]  = rename_tag;
            end
        end
    endtask

    task automatic step();
        #1 compare_reads();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; write_en = 1'b0; clear_all = 1'b0; rename_en = 1'b0;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
        write_en = 1'b1; reg_id = r; rob_id = t; value_in = v;
    endtask

    task automatic rename(input logic [4:0] r, input logic [3:0] t);
        rename_en = 1'b1; rename_rd = r; rename_tag = t;
    endtask

    initial begin
        model_reset();
        rs1_id = 5'd5; rs2_id = 5'd0;
        #2 compare_reads();
        check("reset_value", rs1_value, 32'h0);
        @(negedge clk_in); rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Reset asserted asynchronously between edges after a rename.
        idle(); rename(5'd5, 4'd3); step(); idle();
        check("pre_rst_busy", 32'(rs1_busy), 32'd1);
        #2 rst_in = 1'b1;
        #1 model_reset();
        check("async_rst_busy", 32'(rs1_busy), 32'd0);
        check("async_rst_tag", 32'(rs1_tag), 32'd0);
        compare_reads();
        @(negedge clk_in); rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Basic flow.
        rename(5'd5, 4'd3); step(); idle();
        rs1_id = 5'd5; step();
        check("basic_busy", 32'(rs1_busy), 32'd1);
        check("basic_tag", 32'(rs1_tag), 32'd3);
        commit(5'd5, 4'd3, 32'h1234); step(); idle(); step();
        check("basic_value", rs1_value, 32'h1234);
        check("basic_free", 32'(rs1_busy), 32'd0);

        // Stale commit leaves the younger producer in place.
        rs1_id = 5'd7;
        rename(5'd7, 4'd2); step(); idle();
        rename(5'd7, 4'd9); step(); idle();
        commit(5'd7, 4'd2, 32'hAA); step(); idle(); step();
        check("stale_value", rs1_value, 32'hAA);
        check("stale_busy", 32'(rs1_busy), 32'd1);
        check("stale_tag", 32'(rs1_tag), 32'd9);
        commit(5'd7, 4'd9, 32'hBB); step(); idle(); step();
        check("cur_value", rs1_value, 32'hBB);
        check("cur_busy", 32'(rs1_busy), 32'd0);

        // Commit and rename of x4 in one cycle.
        rs1_id = 5'd4;
        rename(5'd4, 4'd1); step(); idle();
        commit(5'd4, 4'd1, 32'h10); rename(5'd4, 4'd6); step(); idle(); step();
        check("both_value", rs1_value, 32'h10);
        check("both_busy", 32'(rs1_busy), 32'd1);
        check("both_tag", 32'(rs1_tag), 32'd6);

        // Rename squashed by a same-cycle flush.
        rs1_id = 5'd8;
        clear_all = 1'b1; rename(5'd8, 4'd5); step(); idle(); step();
        check("flush_rename", 32'(rs1_busy), 32'd0);

        // x0 is immune to commits.
        rs1_id = 5'd0;
        commit(5'd0, 4'd0, 32'hFF); step(); idle(); step();
        check("x0_value", rs1_value, 32'h0);

        // Flush frees every busy register but keeps values.
        for (int i = 1; i <= 3; i++) begin
            rename(5'(i), 4'(i)); step();
        end
        idle(); clear_all = 1'b1; step(); idle();
        for (int i = 1; i <= 3; i++) begin
            rs1_id = 5'(i); rs2_id = 5'(i); #1;
            check("flush_busy", 32'(rs1_busy), 32'd0);
            compare_reads();
        end

        // Stall: nothing changes while rdy_in is low.
        rs1_id = 5'd6; rs2_id = 5'd6;
        rdy_in = 1'b0; commit(5'd6, 4'd0, 32'h55);
        rename(5'd6, 4'd7);
        repeat (3) step();
        idle(); step();
        check("stall_value", rs1_value, 32'h0);
        check("stall_busy", 32'(rs1_busy), 32'd0);

        // Commit bypass on rs2.
        rs2_id = 5'd9;
        rename(5'd9, 4'd4); step(); idle();
        commit(5'd9, 4'd4, 32'h77); #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        check("bypass_value", rs2_value, 32'h77);
        check("bypass_busy", 32'(rs2_busy), 32'd0);
`else
        check("nobypass_value", rs2_value, 32'h0);
        check("nobypass_busy", 32'(rs2_busy), 32'd1);
`endif
        step(); idle(); step();
        check("late_value", rs2_value, 32'h77);
        check("late_busy", 32'(rs2_busy), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            rdy_in     = $urandom_range(0, 9) != 0;
            write_en   = 1'($urandom);
            reg_id     = 5'($urandom);
            rob_id     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : m_tag[reg_id];
            value_in   = $urandom;
            clear_all  = $urandom_range(0, 19) == 0;
            rename_en  = 1'($urandom);
            rename_rd  = ($urandom_range(0, 3) == 0) ? reg_id : 5'($urandom);
            rename_tag = 4'($urandom);
            rs1_id     = 5'($urandom);
            rs2_id     = ($urandom_range(0, 3) == 0) ? reg_id : 5'($urandom);
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_id = 5'(i); rs2_id = 5'(31 - i);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
